// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, state encoding and fault helper for the data-memory responder
package dmem_pkg;

  localparam int BE_W     = 4;
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 4;

  // Handshake FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // An access faults when it lands beyond the array or is a store that enables no lane
  function automatic logic access_fault(
    input logic [29:0]     idx,
    input logic [29:0]     depth,
    input logic            we,
    input logic [BE_W-1:0] be
  );
    return (idx >= depth) || (we && (be == '0));
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port word RAM with byte-lane writes and registered read, contents kept across reset
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int  DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            en,
  input  logic            we,
  input  logic [BE_W-1:0] be,
  input  logic [AW-1:0]   addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Lane-masked write or word read; the read register holds its value until the next read
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - valid/ready data-memory responder with fixed wait states and fault reporting
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  input  logic [BE_W-1:0] req_be,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    CNT_W'((WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             ready_en;

  logic             we_q;
  logic [AW-1:0]    idx_q;
  logic [31:0]      wdata_q;
  logic [BE_W-1:0]  be_q;
  logic             err_q;

  logic [29:0]      idx_in;
  logic             fault_in;
  logic             accept;
  logic             enter_resp;
  logic             unused_addr_lsb;

  logic             ram_en;
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [31:0]      ram_wdata;
  logic [BE_W-1:0]  ram_be;
  logic             ram_fault;
  logic [31:0]      ram_rdata;

  assign idx_in          = req_addr[31:2];
  assign unused_addr_lsb = ^req_addr[1:0];
  assign fault_in        = access_fault(idx_in, 30'(DEPTH_WORDS), req_we, req_be);

  // req_ready is held off until the first clock edge after reset releases
  assign req_ready = ready_en && (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == ST_RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? ram_rdata : 32'h0;

  // Detect the edge that moves the FSM into RESP; with no wait states that is the accept edge itself
  always_comb begin
    enter_resp = 1'b0;
    if (state == ST_IDLE) begin
      enter_resp = accept && (WAIT_CYCLES == 0);
    end else if (state == ST_WAIT) begin
      enter_resp = (cnt == 4'd1);
    end
  end

  // The RAM sees live inputs on a zero-wait accept, otherwise the request captured at accept
  always_comb begin
    if (state == ST_IDLE) begin
      ram_we    = req_we;
      ram_addr  = idx_in[AW-1:0];
      ram_wdata = req_wdata;
      ram_be    = req_be;
      ram_fault = fault_in;
    end else begin
      ram_we    = we_q;
      ram_addr  = idx_q;
      ram_wdata = wdata_q;
      ram_be    = be_q;
      ram_fault = err_q;
    end
    ram_en = enter_resp && !ram_fault;
  end

  // FSM and wait-state down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (WAIT_CYCLES == 0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd1) begin
            state <= ST_RESP;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture the request on accept; later input changes are ignored until the next IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we;
      idx_q   <= idx_in[AW-1:0];
      wdata_q <= req_wdata;
      be_q    <= req_be;
      err_q   <= fault_in;
    end
  end

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        c0_req_valid;
  logic        c0_req_ready;
  logic        c0_req_we;
  logic [31:0] c0_req_addr;
  logic [31:0] c0_req_wdata;
  logic [3:0]  c0_req_be;
  logic        c0_rsp_valid;
  logic        c0_rsp_ready;
  logic [31:0] c0_rsp_rdata;
  logic        c0_rsp_err;

  int passed;
  int total;
  int failed;

  dmem_responder #(
    .DEPTH_WORDS (1024),
    .WAIT_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  dmem_responder #(
    .DEPTH_WORDS (1024),
    .WAIT_CYCLES (0)
  ) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (c0_req_valid),
    .req_ready (c0_req_ready),
    .req_we    (c0_req_we),
    .req_addr  (c0_req_addr),
    .req_wdata (c0_req_wdata),
    .req_be    (c0_req_be),
    .rsp_valid (c0_rsp_valid),
    .rsp_ready (c0_rsp_ready),
    .rsp_rdata (c0_rsp_rdata),
    .rsp_err   (c0_rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request on the WAIT_CYCLES=2 instance; called just after a falling edge
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rdata, input logic exp_err, input int stall);
    int n;
    chk({tag, "/ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n = 1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = 32'h0000_0FFC;
    req_wdata = 32'hA5A5_A5A5;
    req_be    = 4'b1111;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/latency"}, 32'(n), 32'd3);
    chk({tag, "/rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "/err"}, 32'(rsp_err), 32'(exp_err));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "/stall_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "/stall_rdata"}, rsp_rdata, exp_rdata);
      chk({tag, "/stall_err"}, 32'(rsp_err), 32'(exp_err));
      chk({tag, "/stall_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "/done_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "/done_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int          acc_cyc [3];
    int          rsp_cyc [3];
    logic [31:0] rsp_dat [3];
    int          n_acc;
    int          n_rsp;

    passed = 0;
    total  = 0;
    failed = 0;
    clk    = 1'b0;
    rst_n  = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    c0_req_valid = 1'b0; c0_req_we = 1'b0; c0_req_addr = '0; c0_req_wdata = '0; c0_req_be = '0;
    c0_rsp_ready = 1'b0;

    // Reset state
    #1;
    chk("rst/req_ready", 32'(req_ready), 32'd0);
    chk("rst/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst/rsp_rdata", rsp_rdata, 32'd0);
    chk("rst/rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst/ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("rst/ready_after_edge", 32'(req_ready), 32'd1);

    // Full-word store then load
    do_req("st_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, 0);
    do_req("ld_full", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0, 0);

    // Byte-lane stores
    do_req("st_b0", 1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 1'b0, 0);
    do_req("ld_b0", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEAA, 1'b0, 0);
    do_req("st_hi", 1'b1, 32'h10, 32'h55660000, 4'b1100, 32'h0, 1'b0, 0);
    do_req("ld_hi", 1'b0, 32'h10, 32'h0, 4'b0000, 32'h5566BEAA, 1'b0, 0);

    // Faults: out-of-range load, store with no lanes enabled
    do_req("ld_oob", 1'b0, 32'h00001000, 32'h0, 4'b1111, 32'h0, 1'b1, 0);
    do_req("st_be0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b1, 0);
    do_req("ld_after_be0", 1'b0, 32'h10, 32'h0, 4'b0000, 32'h5566BEAA, 1'b0, 0);

    // Response back-pressure for 5 cycles
    do_req("ld_stall", 1'b0, 32'h10, 32'h0, 4'b0000, 32'h5566BEAA, 1'b0, 5);

    // Reset during WAIT abandons the store
    do_req("st_prior", 1'b1, 32'h20, 32'h11111111, 4'b1111, 32'h0, 1'b0, 0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("wrst/in_wait_valid", 32'(rsp_valid), 32'd0);
    chk("wrst/in_wait_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("wrst/req_ready", 32'(req_ready), 32'd0);
    chk("wrst/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("wrst/rsp_rdata", rsp_rdata, 32'd0);
    chk("wrst/rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_req("ld_after_rst", 1'b0, 32'h20, 32'h0, 4'b0000, 32'h11111111, 1'b0, 0);

    // Zero-wait instance: store then back-to-back loads with rsp_ready held high
    n_acc = 0;
    n_rsp = 0;
    c0_rsp_ready = 1'b1;
    c0_req_valid = 1'b1;
    c0_req_we    = 1'b1;
    c0_req_addr  = 32'h40;
    c0_req_wdata = 32'hCAFEF00D;
    c0_req_be    = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      if (c0_rsp_valid && n_rsp < 3) begin
        rsp_cyc[n_rsp] = k;
        rsp_dat[n_rsp] = c0_rsp_rdata;
        n_rsp++;
      end
      if (c0_req_ready && c0_req_valid && n_acc < 3) begin
        acc_cyc[n_acc] = k;
        n_acc++;
      end else begin
        c0_req_we    = 1'b0;
        c0_req_valid = (n_acc < 3);
      end
      @(negedge clk);
    end
    c0_req_valid = 1'b0;
    chk("w0/n_acc", 32'(n_acc), 32'd3);
    chk("w0/n_rsp", 32'(n_rsp), 32'd3);
    chk("w0/spacing01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
    chk("w0/spacing12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);
    chk("w0/lat0", 32'(rsp_cyc[0] - acc_cyc[0]), 32'd1);
    chk("w0/lat1", 32'(rsp_cyc[1] - acc_cyc[1]), 32'd1);
    chk("w0/lat2", 32'(rsp_cyc[2] - acc_cyc[2]), 32'd1);
    chk("w0/st_rdata", rsp_dat[0], 32'h0);
    chk("w0/ld1_rdata", rsp_dat[1], 32'hCAFEF00D);
    chk("w0/ld2_rdata", rsp_dat[2], 32'hCAFEF00D);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
